// File: rtl/epp_pkg.sv
// Shared types and constants for the EPD waveform packer: drive codes, drive modes and
// default geometry of the waveform LUT and output line.
package epp_pkg;

  localparam int unsigned LUT_PHASES     = 20;
  localparam int unsigned WORDS_PER_LINE = 240;
  localparam int unsigned PHASE_W        = 5;
  localparam int unsigned CNT_W          = 8;

  localparam logic [1:0] EPP_VSS = 2'b00;
  localparam logic [1:0] EPP_BLK = 2'b01;
  localparam logic [1:0] EPP_WHT = 2'b10;
  localparam logic [1:0] EPP_NOP = 2'b11;

  typedef enum logic [1:0] {
    ModeLut = 2'b00,
    ModeBlk = 2'b01,
    ModeWht = 2'b10,
    ModeNop = 2'b11
  } epp_mode_e;

  // Forced modes share their encoding with the drive code they force.
  function automatic logic [1:0] epp_forced_code(epp_mode_e m);
    return 2'(m);
  endfunction

endpackage

// File: rtl/epp_wave_packer_if.sv
// Pixel-in / source-word-out streams of the waveform packer, both valid/ready.
interface epp_wave_packer_if;

  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pix_data;

  logic        src_valid;
  logic        src_ready;
  logic [15:0] src_data;

  // master: pixel feeder and source-word consumer; slave: the packer
  modport master (
    output pix_valid, pix_data, src_ready,
    input  pix_ready, src_valid, src_data
  );

  modport slave (
    input  pix_valid, pix_data, src_ready,
    output pix_ready, src_valid, src_data
  );

endinterface

// File: rtl/epp_code_lut.sv
// 16-entry waveform LUT with one write port and four parallel combinational read ports
// that turn a 4-pixel input word into four 2-bit drive codes.
module epp_code_lut
  import epp_pkg::*;
#(
  parameter int unsigned LutPhases = LUT_PHASES,
  parameter int unsigned PhaseW    = PHASE_W
) (
  input  logic                   clk_i,
  input  logic                   wr_en_i,
  input  logic [3:0]             wr_addr_i,
  input  logic [2*LutPhases-1:0] wr_data_i,
  input  logic [PhaseW-1:0]      phase_i,
  input  epp_mode_e              mode_i,
  input  logic [15:0]            pix_data_i,
  output logic [7:0]             codes_o
);

  localparam int unsigned EntryW = 2 * LutPhases;

  logic [EntryW-1:0] lut_q [16];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      lut_q[wr_addr_i] <= wr_data_i;
    end
  end

  logic        phase_in_range;
  int unsigned shamt;

  // Phase 0 sits in the MSB pair, so later phases shift less.
  always_comb begin
    phase_in_range = 32'(phase_i) < LutPhases;
    shamt          = (LutPhases - 32'd1 - 32'(phase_i)) << 1;
  end

  for (genvar i = 0; i < 4; i++) begin : g_port
    logic [3:0] gray;
    logic [1:0] lut_code;
    logic [1:0] code;

    assign gray     = pix_data_i[4*(3-i) +: 4];
    assign lut_code = 2'(lut_q[gray] >> shamt);

    always_comb begin
      if (mode_i == ModeLut) begin
        code = phase_in_range ? lut_code : EPP_VSS;
      end else begin
        code = epp_forced_code(mode_i);
      end
    end

    assign codes_o[2*(3-i) +: 2] = code;
  end

endmodule

// File: rtl/epp_wave_packer.sv
// Packs two 4-pixel input words into one 16-bit source-drive word per handshake, one line
// of WordsPerLine words per line_start, with abort/underrun/LUT-write error reporting.
module epp_wave_packer
  import epp_pkg::*;
#(
  parameter int unsigned LutPhases    = LUT_PHASES,
  parameter int unsigned WordsPerLine = WORDS_PER_LINE,
  parameter int unsigned PhaseW       = PHASE_W,
  parameter int unsigned CntW         = CNT_W
) (
  input  logic                   glb_clk,
  input  logic                   glb_nrst,
  input  logic                   frame_start,
  input  logic [PhaseW-1:0]      phase,
  input  logic [1:0]             mode,
  input  logic                   line_start,
  input  logic                   lut_wr,
  input  logic [3:0]             lut_addr,
  input  logic [2*LutPhases-1:0] lut_data,
  epp_wave_packer_if.slave       bus,
  output logic                   line_active,
  output logic                   line_done,
  output logic                   underrun,
  output logic                   lut_wr_err,
  output logic                   abort
);

  localparam logic [CntW-1:0] LastCnt = CntW'(WordsPerLine - 1);

  logic              half_q, half_d;
  logic [CntW-1:0]   word_cnt_q, word_cnt_d;
  logic [PhaseW-1:0] phase_q, phase_d;
  epp_mode_e         mode_q, mode_d;
  logic [7:0]        hold_q, hold_d;
  logic              src_valid_q, src_valid_d;
  logic [15:0]       src_data_q, src_data_d;
  logic              line_active_q, line_active_d;
  logic              underrun_q, underrun_d;
  logic              lut_wr_err_q, lut_wr_err_d;
  logic              abort_q, abort_d;
  logic              ls_seen_q, ls_seen_d;

  logic [7:0] codes;
  logic       pix_ready;
  logic       pix_fire;
  logic       src_fire;
  logic       last_word;
  logic       lut_wr_ok;

  epp_code_lut #(
    .LutPhases(LutPhases),
    .PhaseW   (PhaseW)
  ) u_code_lut (
    .clk_i     (glb_clk),
    .wr_en_i   (lut_wr_ok),
    .wr_addr_i (lut_addr),
    .wr_data_i (lut_data),
    .phase_i   (phase_q),
    .mode_i    (mode_q),
    .pix_data_i(bus.pix_data),
    .codes_o   (codes)
  );

  // Second half may only be taken when the output slot is free or draining this cycle.
  assign pix_ready = line_active_q & (~half_q | ~src_valid_q | bus.src_ready);
  assign pix_fire  = bus.pix_valid & pix_ready;
  assign src_fire  = src_valid_q & bus.src_ready;
  assign last_word = src_fire & (word_cnt_q == LastCnt);
  assign lut_wr_ok = lut_wr & ~line_active_q;

  always_comb begin
    half_d        = half_q;
    word_cnt_d    = word_cnt_q;
    phase_d       = phase_q;
    mode_d        = mode_q;
    hold_d        = hold_q;
    src_valid_d   = src_valid_q;
    src_data_d    = src_data_q;
    line_active_d = line_active_q;
    underrun_d    = underrun_q;
    abort_d       = abort_q;
    lut_wr_err_d  = lut_wr & line_active_q;
    ls_seen_d     = line_start;

    if (frame_start) begin
      phase_d = phase;
      mode_d  = epp_mode_e'(mode);
    end

    // Clear on handshake first so a same-cycle reload below keeps the word valid.
    if (src_fire) begin
      src_valid_d = 1'b0;
      word_cnt_d  = last_word ? '0 : word_cnt_q + CntW'(1);
    end
    if (last_word) begin
      line_active_d = 1'b0;
    end

    if (pix_fire) begin
      if (!half_q) begin
        hold_d = codes;
        half_d = 1'b1;
      end else begin
        src_data_d  = {hold_q, codes};
        src_valid_d = 1'b1;
        half_d      = 1'b0;
      end
    end

    if (line_start) begin
      line_active_d = 1'b1;
      word_cnt_d    = '0;
      if (line_active_q && !last_word) begin
        abort_d     = 1'b1;
        half_d      = 1'b0;
        src_valid_d = 1'b0;
      end
    end

    if (bus.src_ready && line_active_q && !src_valid_q && !ls_seen_q) begin
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge glb_clk or negedge glb_nrst) begin
    if (!glb_nrst) begin
      half_q        <= 1'b0;
      word_cnt_q    <= '0;
      phase_q       <= '0;
      mode_q        <= ModeLut;
      hold_q        <= '0;
      src_valid_q   <= 1'b0;
      src_data_q    <= '0;
      line_active_q <= 1'b0;
      underrun_q    <= 1'b0;
      lut_wr_err_q  <= 1'b0;
      abort_q       <= 1'b0;
      ls_seen_q     <= 1'b0;
    end else begin
      half_q        <= half_d;
      word_cnt_q    <= word_cnt_d;
      phase_q       <= phase_d;
      mode_q        <= mode_d;
      hold_q        <= hold_d;
      src_valid_q   <= src_valid_d;
      src_data_q    <= src_data_d;
      line_active_q <= line_active_d;
      underrun_q    <= underrun_d;
      lut_wr_err_q  <= lut_wr_err_d;
      abort_q       <= abort_d;
      ls_seen_q     <= ls_seen_d;
    end
  end

  assign bus.pix_ready = pix_ready;
  assign bus.src_valid = src_valid_q;
  assign bus.src_data  = src_data_q;
  assign line_active   = line_active_q;
  assign line_done     = last_word;
  assign underrun      = underrun_q;
  assign lut_wr_err    = lut_wr_err_q;
  assign abort         = abort_q;

endmodule
